// File: rtl/mem_ctrl_pkg.sv
// Shared constants for mem_ctrl: request sizes, FSM states, operation kinds and the IO window.
package mem_ctrl_pkg;

  localparam logic [1:0]  SIZE_B  = 2'd0;
  localparam logic [1:0]  SIZE_H  = 2'd1;
  localparam logic [1:0]  SIZE_W  = 2'd2;
  localparam logic [31:0] IO_MASK = 32'h0003_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_t;

  // Index of the last byte lane touched by an access of the given size.
  function automatic logic [1:0] last_lane(input logic [1:0] size);
    case (size)
      SIZE_B:  return 2'd0;
      SIZE_H:  return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic in_io(input logic [31:0] addr);
    return (addr & IO_MASK) == IO_MASK;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bundle between mem_ctrl, the icache, the LSB and the byte-wide RAM/IO port.
interface mem_ctrl_if;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        icache_miss;
  logic [31:0] icache_addr;
  logic        icache_busy;
  logic        icache_valid;
  logic [31:0] icache_instr;
  logic        lsb_valid;
  logic        lsb_wr;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_data;
  logic        lsb_ready;
  logic [31:0] lsb_data_out;

  modport master (
    input  mem_din, io_buffer_full, icache_miss, icache_addr,
           lsb_valid, lsb_wr, lsb_size, lsb_addr, lsb_data,
    output mem_dout, mem_a, mem_wr, icache_busy, icache_valid, icache_instr,
           lsb_ready, lsb_data_out
  );

  modport slave (
    output mem_din, io_buffer_full, icache_miss, icache_addr,
           lsb_valid, lsb_wr, lsb_size, lsb_addr, lsb_data,
    input  mem_dout, mem_a, mem_wr, icache_busy, icache_valid, icache_instr,
           lsb_ready, lsb_data_out
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates icache misses and LSB loads/stores onto one byte-wide RAM/IO port (LSB first).
// Load n bytes -> ready at t+n+2, store -> t+n+1 plus IO-full stalls, fetch -> t+4/t+6; rdy_in low freezes all.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic       flush,
  mem_ctrl_if.master bus
);

  state_t      state, state_nx;
  op_t         op;
  logic [1:0]  cnt, cnt_inc, last_idx;
  logic        rd_pend, io_q, accept, stall;
  logic [31:0] st_dat, asm_q, mem_a_q;
  logic [7:0]  mem_dout_q;

  assign cnt_inc = cnt + 2'd1;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    stall    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!flush && (bus.lsb_valid || bus.icache_miss)) begin
          accept = 1'b1;
          if (bus.lsb_valid) state_nx = bus.lsb_wr ? ST_STORE : ST_LOAD;
          else               state_nx = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Byte 0 is already in the lane register when byte 1 lands, so the length is known then.
        if (flush)
          state_nx = ST_IDLE;
        else if (rd_pend && ((cnt == 2'd3) || (cnt == 2'd1 && asm_q[1:0] != 2'b11)))
          state_nx = ST_DONE;
      end
      ST_LOAD: begin
        if (flush)                              state_nx = ST_IDLE;
        else if (rd_pend && (cnt == last_idx)) state_nx = ST_DONE;
      end
      ST_STORE: begin
        stall = io_q && bus.io_buffer_full;
        if (!stall && (cnt == last_idx)) state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      op         <= OP_FETCH;
      cnt        <= 2'd0;
      last_idx   <= 2'd0;
      rd_pend    <= 1'b0;
      io_q       <= 1'b0;
      st_dat     <= 32'd0;
      asm_q      <= 32'd0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
    end else if (rdy_in) begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bus.lsb_valid) op <= bus.lsb_wr ? OP_STORE : OP_LOAD;
            else               op <= OP_FETCH;
            mem_a_q    <= bus.lsb_valid ? bus.lsb_addr : bus.icache_addr;
            last_idx   <= bus.lsb_valid ? last_lane(bus.lsb_size) : 2'd3;
            io_q       <= bus.lsb_valid && bus.lsb_wr && in_io(bus.lsb_addr);
            st_dat     <= bus.lsb_data;
            mem_dout_q <= bus.lsb_data[7:0];
            asm_q      <= 32'd0;
            cnt        <= 2'd0;
            rd_pend    <= 1'b0;
          end
        end
        ST_FETCH, ST_LOAD: begin
          mem_a_q <= mem_a_q + 32'd1;
          rd_pend <= 1'b1;
          if (rd_pend) begin
            asm_q[{cnt, 3'b000} +: 8] <= bus.mem_din;
            cnt                       <= cnt_inc;
          end
        end
        ST_STORE: begin
          if (!stall) begin
            mem_a_q    <= mem_a_q + 32'd1;
            cnt        <= cnt_inc;
            mem_dout_q <= st_dat[{cnt_inc, 3'b000} +: 8];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_a        = mem_a_q;
  assign bus.mem_dout     = mem_dout_q;
  assign bus.mem_wr       = (state == ST_STORE) && !stall;
  assign bus.icache_busy  = (state != ST_IDLE);
  // A flush landing on the pulse cycle cancels fetch/load results; stores have already committed.
  assign bus.icache_valid = (state == ST_DONE) && (op == OP_FETCH) && !flush;
  assign bus.lsb_ready    = (state == ST_DONE) &&
                            ((op == OP_STORE) || ((op == OP_LOAD) && !flush));
  assign bus.icache_instr = asm_q;
  assign bus.lsb_data_out = asm_q;

endmodule
